// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants for the FIFO read-side stream adapter.
//   BUF_DEPTH : entries in the output buffer
//   CNT_W     : width of the completed-handshake counter
//   RD_LAT    : read latency of the upstream synchronous FIFO, in cycles
//   PTR_W     : width of the buffer read/write pointers
package fifo_rd_stream_pkg;

    localparam int BUF_DEPTH = 3;
    localparam int CNT_W     = 16;
    localparam int RD_LAT    = 1;
    localparam int PTR_W     = 2;

    // Circular pointer advance over BUF_DEPTH entries (0,1,2,0,...).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/skid_buf3.sv
// Three-entry register FIFO used as the adapter's output buffer.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   push        : write push_data at the tail this edge
//   push_data   : word to write
//   pop         : remove the head entry this edge (ignored when empty)
//   head_data   : current head entry, 0 when the buffer is empty
//   occupancy   : number of words held, 0..3
module skid_buf3
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [1:0]       count;
    logic             pop_eff;

    assign pop_eff = pop & (count != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_eff) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop_eff})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Data storage carries no reset; the empty mask on head_data below keeps
    // stale contents from ever reaching the output.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = (count != 2'd0) ? mem[rd_ptr] : '0;
    assign occupancy = count;

    // The upstream credit rule must never let a word land on a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && count == 2'(BUF_DEPTH)));

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter for a synchronous FIFO with one cycle of read latency.
// Drains the FIFO through rd/empty/q and presents the words as a
// valid/ready stream. A 3-entry buffer absorbs the read latency so a
// steady consumer sees one word per cycle; fifo_rd is computed from
// registered state and FIFO flags only, never from out_ready.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   en          : 1 allows new FIFO reads
//   fifo_empty  : FIFO empty flag
//   fifo_q      : FIFO read data, valid one cycle after fifo_rd
//   fifo_rd     : FIFO read request
//   out_data    : stream data (buffer head)
//   out_valid   : stream valid
//   out_ready   : stream ready from consumer
//   occupancy   : words held in the output buffer, 0..3
//   xfer_cnt    : completed handshakes, wrapping
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_q,
    output logic             fifo_rd,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic       inflight;
    logic       pop;
    logic [2:0] credits_used;

    // Words already buffered plus the word still in flight from the FIFO
    // must stay below the buffer depth before another read may be issued.
    assign credits_used = {1'b0, occupancy} + {2'b00, inflight};

    // rst gating keeps the request low while reset is held, even if the
    // FIFO reports data and draining is enabled.
    assign fifo_rd = ~rst & en & ~fifo_empty & (credits_used < 3'(BUF_DEPTH));

    assign out_valid = (occupancy != 2'd0);
    assign pop       = out_valid & out_ready;

    // Read issued last cycle: its data is on fifo_q now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            inflight <= fifo_rd;
            if (pop) begin
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
        end
    end

    skid_buf3 #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (fifo_q),
        .pop       (pop),
        .head_data (out_data),
        .occupancy (occupancy)
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             en;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_q;
    logic             fifo_rd;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       occupancy;
    logic [15:0]      xfer_cnt;

    fifo_rd_stream #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .fifo_rd    (fifo_rd),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .occupancy  (occupancy),
        .xfer_cnt   (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference: an upstream FIFO as a queue, plus the list of words the
    // consumer must receive in order (everything written to the FIFO).
    logic [WIDTH-1:0] fifo_model [$];
    logic [WIDTH-1:0] exp_q      [$];
    logic [15:0]      model_cnt  = 16'd0;

    int cyc       = 0;
    int rd_count  = 0;
    int hs_count  = 0;
    int first_rd  = -1;
    int first_vld = -1;
    int hs_cyc [$];
    logic rd_seen    = 1'b0;
    logic stall_prev = 1'b0;
    logic [WIDTH-1:0] held_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc++;

    // Upstream FIFO: a read request seen this cycle returns data after the edge.
    always @(posedge clk) begin
        #1;
        if (rd_seen && !rst && fifo_model.size() > 0) begin
            fifo_q = fifo_model.pop_front();
        end
        fifo_empty = (fifo_model.size() == 0);
    end

    // Monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            rd_seen    = 1'b0;
            stall_prev = 1'b0;
        end else begin
            rd_seen = fifo_rd;
            if (fifo_rd) begin
                rd_count++;
                if (first_rd < 0) first_rd = cyc;
                check("rd_while_empty", {31'd0, fifo_empty}, 32'd0);
            end
            if (out_valid && first_vld < 0) first_vld = cyc;
            check("valid_vs_occ", {31'd0, out_valid}, {31'd0, (occupancy != 2'd0)});
            check("xfer_cnt", {16'd0, xfer_cnt}, {16'd0, model_cnt});
            if (stall_prev && out_valid) check("hold_data", {24'd0, out_data}, {24'd0, held_data});
            stall_prev = out_valid && !out_ready;
            held_data  = out_data;
            if (out_valid && out_ready) begin
                hs_count++;
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {24'd0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    check("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
                end
                model_cnt = model_cnt + 16'd1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        fifo_model.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic clear_stats();
        rd_count  = 0;
        hs_count  = 0;
        first_rd  = -1;
        first_vld = -1;
        hs_cyc.delete();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((fifo_model.size() != 0 || exp_q.size() != 0 || occupancy != 2'd0) && n < budget) begin
            step(1);
            n++;
        end
        if (n >= budget) check({"timeout_", name}, 32'd0, 32'd1);
        step(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst        = 1'b1;
        en         = 1'b0;
        out_ready  = 1'b0;
        fifo_empty = 1'b1;
        fifo_q     = '0;
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_occ", {30'd0, occupancy}, 32'd0);
        step(3);
        rst = 1'b0;
        step(2);

        // Streaming from a preloaded FIFO.
        clear_stats();
        for (int i = 1; i <= 4; i++) push_word(8'(i));
        out_ready = 1'b1;
        step(1);
        en = 1'b1;
        wait_idle("stream", 40);
        check("stream_hs", hs_count, 32'd4);
        check("stream_gapless", hs_cyc.size() == 4 ? hs_cyc[3] - hs_cyc[0] : -1, 32'd3);
        check("stream_latency", first_vld - first_rd, 32'd2);
        check("stream_xfer", {16'd0, xfer_cnt}, 32'd4);

        // Reset with two words buffered and the FIFO non-empty.
        out_ready = 1'b0;
        push_word(8'h11);
        push_word(8'h22);
        n = 0;
        while (occupancy != 2'd2 && n < 20) begin step(1); n++; end
        check("rst_prefill_occ", {30'd0, occupancy}, 32'd2);
        push_word(8'h33);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_rd", {31'd0, fifo_rd}, 32'd0);
        check("rst_mid_occ", {30'd0, occupancy}, 32'd0);
        check("rst_mid_xfer", {16'd0, xfer_cnt}, 32'd0);
        check("rst_mid_data", {24'd0, out_data}, 32'd0);
        fifo_model.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        model_cnt  = 16'd0;
        step(2);
        rst = 1'b0;
        step(2);

        // Backpressure: only three reads may be outstanding.
        clear_stats();
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push_word(8'(i));
        step(10);
        check("bp_rd_pulses", rd_count, 32'd3);
        check("bp_occ", {30'd0, occupancy}, 32'd3);
        check("bp_rd_low", {31'd0, fifo_rd}, 32'd0);
        check("bp_head", {24'd0, out_data}, 32'h01);
        check("bp_fifo_left", fifo_model.size(), 32'd3);
        out_ready = 1'b1;
        wait_idle("backpressure", 40);
        check("bp_rd_total", rd_count, 32'd6);
        check("bp_hs_total", hs_count, 32'd6);

        // Underflow guard with a single word.
        clear_stats();
        push_word(8'hA5);
        wait_idle("single", 20);
        step(3);
        check("single_rd", rd_count, 32'd1);
        check("single_hs", hs_count, 32'd1);

        // Enable dropped while the first read is in flight.
        clear_stats();
        for (int i = 0; i < 5; i++) push_word(8'h40 + 8'(i));
        step(1);
        en = 1'b0;
        step(8);
        check("en_rd", rd_count, 32'd1);
        check("en_hs", hs_count, 32'd1);
        check("en_fifo_left", fifo_model.size(), 32'd4);
        check("en_occ", {30'd0, occupancy}, 32'd0);
        en = 1'b1;
        wait_idle("enable", 40);
        check("en_rd_total", rd_count, 32'd5);
        check("en_hs_total", hs_count, 32'd5);

        // Counter wrap.
        force dut.xfer_cnt = 16'hFFFE;
        #1;
        release dut.xfer_cnt;
        model_cnt = 16'hFFFE;
        step(1);
        for (int i = 0; i < 3; i++) push_word(8'hC0 + 8'(i));
        wait_idle("wrap", 40);
        check("wrap_xfer", {16'd0, xfer_cnt}, 32'd1);

        // Randomized traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            step(1);
            if ($urandom_range(0, 99) < 45) push_word(8'($urandom));
            en        = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 99) < 60);
        end
        en        = 1'b1;
        out_ready = 1'b1;
        wait_idle("random", 600);
        check("random_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
